// File: rtl/line_fill_arbiter.sv
// line_fill_arbiter: shares one main-memory req/ack port between the I-cache
// refill path and the D-cache refill/writeback path. Whole lines are granted
// round-robin and then sequenced one word per handshake.
// Optional build macro: LINE_FILL_ARBITER_TIMEOUT_EN adds a per-beat ack
// watchdog and the sticky err output.
module line_fill_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int WORDS_PER_LINE = 8,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int BEAT_W        = $clog2(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_gnt,
    output logic              ic_rvalid,
    output logic              ic_done,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_gnt,
    output logic              dc_rvalid,
    output logic              dc_wready,
    output logic              dc_done,
    output logic [31:0]       rdata,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              mm_req,
    output logic              mm_we,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [31:0]       mm_wdata,
    input  logic              mm_ack,
    input  logic [31:0]       mm_rdata
`ifdef LINE_FILL_ARBITER_TIMEOUT_EN
    ,
    output logic              err
`endif
);

    localparam int OFF_W = BEAT_W + 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_LINE - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Owner encoding: index into the per-requester output vectors
    localparam logic OWN_IC = 1'b0;
    localparam logic OWN_DC = 1'b1;

    logic [1:0]              state_reg;
    logic                    owner_reg;
    logic                    last_owner_reg;
    logic                    we_reg;
    logic [ADDR_W-OFF_W-1:0] base_reg;
    logic [BEAT_W-1:0]       beat_reg;
    logic                    pick_dc_next;
    logic                    timeout_hit;
    logic                    in_burst;

    logic [1:0] gnt_vec;
    logic [1:0] done_vec;
    logic [1:0] rvalid_vec;

    assign in_burst = (state_reg == BURST);

    // Round-robin choice: the D-cache wins alone, or on a tie when the I-cache had the last line
    always_comb begin
        pick_dc_next = dc_req && (!ic_req || (last_owner_reg == OWN_IC));
    end

    // Main FSM: grant a line, step through its beats, then one DONE cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= OWN_IC;
            last_owner_reg <= OWN_DC;
            we_reg         <= 1'b0;
            base_reg       <= '0;
            beat_reg       <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (ic_req || dc_req) begin
                        owner_reg <= pick_dc_next;
                        we_reg    <= pick_dc_next & dc_we;
                        base_reg  <= pick_dc_next ? dc_addr[ADDR_W-1:OFF_W]
                                                  : ic_addr[ADDR_W-1:OFF_W];
                        beat_reg  <= '0;
                        state_reg <= BURST;
                    end
                end
                BURST: begin
                    if (mm_ack) begin
                        beat_reg <= beat_reg + 1'b1;
                        if (beat_reg == LAST_BEAT) begin
                            state_reg <= DONE;
                        end
                    end else if (timeout_hit) begin
                        beat_reg  <= '0;
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    last_owner_reg <= owner_reg;
                    state_reg      <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef LINE_FILL_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;
    logic             err_reg;

    assign timeout_hit = in_burst && !mm_ack &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    assign err = err_reg;

    // Beat watchdog: counts ack-less burst cycles, held at zero outside BURST
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else if (!in_burst || mm_ack) begin
            wait_cnt_reg <= '0;
        end else if (timeout_hit) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b1;
        end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end

    logic unused_ok;
    assign unused_ok = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0]};
`else
    assign timeout_hit = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{ic_addr[OFF_W-1:0], dc_addr[OFF_W-1:0], (TIMEOUT_CYCLES != 0)};
`endif

    // Per-requester grant, read-valid and done decode; only the owner can see any of them
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign gnt_vec[gi]    = in_burst && (owner_reg == 1'(gi));
        assign done_vec[gi]   = (state_reg == DONE) && (owner_reg == 1'(gi));
        assign rvalid_vec[gi] = gnt_vec[gi] && !we_reg && mm_ack;
    end

    assign ic_gnt    = gnt_vec[OWN_IC];
    assign dc_gnt    = gnt_vec[OWN_DC];
    assign ic_done   = done_vec[OWN_IC];
    assign dc_done   = done_vec[OWN_DC];
    assign ic_rvalid = rvalid_vec[OWN_IC];
    assign dc_rvalid = rvalid_vec[OWN_DC];
    assign dc_wready = gnt_vec[OWN_DC] && we_reg && mm_ack;

    assign rdata     = mm_rdata;
    assign mm_wdata  = dc_wdata;
    assign beat_idx  = beat_reg;
    assign mm_req    = in_burst;
    assign mm_we     = in_burst && we_reg;
    assign mm_addr   = {base_reg, beat_reg, 2'b00};

endmodule

// File: tb/tb_line_fill_arbiter.sv
// Directed bench for line_fill_arbiter: a table of whole-line transactions
// plus hand-written reset-abort and (with LINE_FILL_ARBITER_TIMEOUT_EN) timeout sequences.
module tb_line_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt, ic_rvalid, ic_done;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic        dc_gnt, dc_rvalid, dc_wready, dc_done;
    logic [31:0] rdata;
    logic [2:0]  beat_idx;
    logic        mm_req, mm_we;
    logic [31:0] mm_addr, mm_wdata;
    logic        mm_ack;
    logic [31:0] mm_rdata;
`ifdef LINE_FILL_ARBITER_TIMEOUT_EN
    logic        err;
`endif

    line_fill_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .ic_rvalid(ic_rvalid), .ic_done(ic_done),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
        .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid), .dc_wready(dc_wready), .dc_done(dc_done),
        .rdata(rdata), .beat_idx(beat_idx),
        .mm_req(mm_req), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata),
        .mm_ack(mm_ack), .mm_rdata(mm_rdata)
`ifdef LINE_FILL_ARBITER_TIMEOUT_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem [logic [31:0]];

    typedef struct {
        logic        ic_req;
        logic [31:0] ic_addr;
        logic        dc_req;
        logic        dc_we;
        logic [31:0] dc_addr;
        int          gap;       // idle cycles before each ack
        bit          chg;       // disturb D-cache inputs during beat 3
        logic        exp_dc;    // expected owner is the D-cache
        logic [31:0] exp_base;
        logic        exp_we;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'h5A5A_0000;
    endfunction

    task automatic step_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input vec_t v, input int idx);
        logic [31:0] ea;
        logic        ack;
        ic_req  = v.ic_req;
        ic_addr = v.ic_addr;
        dc_req  = v.dc_req;
        dc_we   = v.dc_we;
        dc_addr = v.dc_addr;
        mm_ack  = 1'b0;
        if (v.exp_we) begin
            for (int k = 0; k < 8; k++) mem[v.exp_base + 32'(k * 4)] = 32'h0;
        end
        @(negedge clk);
        chk("idle_gnt_req", {29'd0, ic_gnt, dc_gnt, mm_req}, 32'd0);
        step_edge();
        for (int b = 0; b < 8; b++) begin
            for (int g = 0; g <= v.gap; g++) begin
                ack      = (g == v.gap);
                ea       = v.exp_base + 32'(b * 4);
                mm_ack   = ack;
                mm_rdata = ack ? rd_val(ea) : 32'hDEAD_BEEF;
                dc_wdata = 32'(b + 1);
                if (v.chg && b == 3) begin
                    dc_addr = 32'hFFFF_FFC0;
                    dc_req  = 1'b0;
                    dc_we   = ~v.exp_we;
                end
                @(negedge clk);
                chk("gnt_pair", {30'd0, ic_gnt, dc_gnt}, v.exp_dc ? 32'd1 : 32'd2);
                chk("mm_req", {31'd0, mm_req}, 32'd1);
                chk("mm_addr", mm_addr, ea);
                chk("mm_we", {31'd0, mm_we}, {31'd0, v.exp_we});
                chk("beat_idx", {29'd0, beat_idx}, 32'(b));
                chk("ic_rvalid", {31'd0, ic_rvalid}, {31'd0, ack && !v.exp_dc});
                chk("dc_rvalid", {31'd0, dc_rvalid}, {31'd0, ack && v.exp_dc && !v.exp_we});
                chk("dc_wready", {31'd0, dc_wready}, {31'd0, ack && v.exp_dc && v.exp_we});
                if (ack && !v.exp_we) chk("rdata", rdata, rd_val(ea));
                if (ack && v.exp_we) begin
                    chk("mm_wdata", mm_wdata, 32'(b + 1));
                    mem[mm_addr] = mm_wdata;
                end
                step_edge();
            end
        end
        mm_ack = 1'b0;
        @(negedge clk);
        chk("done_pair", {30'd0, ic_done, dc_done}, v.exp_dc ? 32'd1 : 32'd2);
        chk("done_gnt_req", {29'd0, ic_gnt, dc_gnt, mm_req}, 32'd0);
        chk("done_beat", {29'd0, beat_idx}, 32'd0);
        step_edge();
        if (v.exp_we) begin
            for (int k = 0; k < 8; k++)
                chk("mem_written", mem[v.exp_base + 32'(k * 4)], 32'(k + 1));
        end
        $display("line %0d: owner=%s base=%h we=%0d gap=%0d", idx,
                 v.exp_dc ? "DC" : "IC", v.exp_base, v.exp_we, v.gap);
    endtask

    task automatic chk_all_quiet(input string tag);
        chk({tag, "_gnt"}, {30'd0, ic_gnt, dc_gnt}, 32'd0);
        chk({tag, "_done"}, {30'd0, ic_done, dc_done}, 32'd0);
        chk({tag, "_mm"}, {30'd0, mm_req, mm_we}, 32'd0);
        chk({tag, "_valid"}, {29'd0, ic_rvalid, dc_rvalid, dc_wready}, 32'd0);
        chk({tag, "_beat"}, {29'd0, beat_idx}, 32'd0);
        chk({tag, "_addr"}, mm_addr, 32'd0);
    endtask

    vec_t vecs [6];
    vec_t fresh;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_011C, 1'b1, 1'b0, 32'h0000_020C, 0, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        vecs[1] = '{1'b1, 32'h0000_011C, 1'b1, 1'b0, 32'h0000_020C, 0, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_011C, 1'b1, 1'b0, 32'h0000_020C, 0, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
        vecs[3] = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0000, 3, 1'b0, 1'b0, 32'h0000_0040, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_6020, 1, 1'b0, 1'b1, 32'h0000_6020, 1'b1};
        vecs[5] = '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_3000, 0, 1'b1, 1'b1, 32'h0000_3000, 1'b0};
        fresh   = '{1'b1, 32'h0000_0A00, 1'b0, 1'b0, 32'h0000_0000, 0, 1'b0, 1'b0, 32'h0000_0A00, 1'b0};

        rst_n = 1'b0; ic_req = 1'b0; ic_addr = '0; dc_req = 1'b0; dc_we = 1'b0;
        dc_addr = '0; dc_wdata = '0; mm_ack = 1'b0; mm_rdata = '0;
        step_edge();
        step_edge();
        rst_n = 1'b1;
        @(negedge clk);
        chk_all_quiet("reset");
        step_edge();

        for (int i = 0; i < 6; i++) run_burst(vecs[i], i);

        // Reset during beat 5 aborts the line with no done pulse
        ic_req = 1'b1; ic_addr = 32'h0000_0080; dc_req = 1'b0; mm_ack = 1'b0;
        step_edge();
        for (int b = 0; b < 5; b++) begin
            mm_ack = 1'b1; mm_rdata = rd_val(32'h80 + 32'(b * 4));
            step_edge();
        end
        mm_ack = 1'b0;
        @(negedge clk);
        chk("pre_rst_beat", {29'd0, beat_idx}, 32'd5);
        chk("pre_rst_gnt", {31'd0, ic_gnt}, 32'd1);
        rst_n = 1'b0; mm_ack = 1'b1;
        step_edge();
        rst_n = 1'b1; ic_req = 1'b0;
        @(negedge clk);
        chk_all_quiet("post_rst");
        step_edge();
        @(negedge clk);
        chk_all_quiet("post_rst2");
        mm_ack = 1'b0;
        step_edge();
        $display("line abort: reset during beat 5");
        run_burst(fresh, 6);

`ifdef LINE_FILL_ARBITER_TIMEOUT_EN
        begin
            int cyc;
            ic_req = 1'b1; ic_addr = 32'h0000_0040; dc_req = 1'b0; mm_ack = 1'b0;
            step_edge();
            cyc = 0;
            @(negedge clk);
            while (!ic_done && cyc < 200) begin
                step_edge();
                cyc++;
                @(negedge clk);
            end
            chk("timeout_cycles", 32'(cyc), 32'd64);
            chk("timeout_done", {31'd0, ic_done}, 32'd1);
            chk("timeout_err", {31'd0, err}, 32'd1);
            ic_req = 1'b0;
            step_edge();
            step_edge();
            @(negedge clk);
            chk("err_sticky", {31'd0, err}, 32'd1);
            chk("timeout_idle", {31'd0, mm_req}, 32'd0);
            rst_n = 1'b0;
            step_edge();
            rst_n = 1'b1;
            @(negedge clk);
            chk("err_cleared", {31'd0, err}, 32'd0);
            $display("line timeout: done after %0d ack-less cycles", cyc);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/line_fill_arbiter.md
Name: line_fill_arbiter

Overview:
- Shares the single backing main-memory port between the instruction-cache refill path and the data-cache refill/writeback path.
- Sits between both cache controllers and main memory, below the Memory wrapper.
- Arbitrates whole 8-word line transfers, not single words, using round-robin.
- Sequences each burst one word at a time over a req/ack handshake to main memory.

Parameters:
- ADDR_W, 32, byte address width.
- WORDS_PER_LINE, 8, beats per burst; must be a power of two.
- TIMEOUT_CYCLES, 64, maximum wait for MM_ACK on one beat. Used only with the optional feature.

Ports:
- MEM_CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- IC_REQ  in  1  I-cache line refill request.
- IC_ADDR  in  ADDR_W  I-cache line address; low log2(WORDS_PER_LINE)+2 bits ignored.
- IC_GNT  out  1  I-cache owns the burst.
- IC_RVALID  out  1  beat read data valid for the I-cache.
- IC_DONE  out  1  one-cycle pulse when the I-cache burst completes.
- DC_REQ  in  1  D-cache request.
- DC_WE  in  1  1 = writeback burst, 0 = refill burst.
- DC_ADDR  in  ADDR_W  D-cache line address; low bits ignored.
- DC_WDATA  in  32  writeback word for the current BEAT_IDX.
- DC_GNT  out  1  D-cache owns the burst.
- DC_RVALID  out  1  beat read data valid for the D-cache.
- DC_WREADY  out  1  current writeback beat accepted.
- DC_DONE  out  1  one-cycle pulse when the D-cache burst completes.
- RDATA  out  32  read data, shared by both requesters (equals MM_RDATA).
- BEAT_IDX  out  log2(WORDS_PER_LINE)  word index of the current beat.
- MM_REQ  out  1  main-memory beat request.
- MM_WE  out  1  beat is a write.
- MM_ADDR  out  ADDR_W  word-aligned beat address.
- MM_WDATA  out  32  write data (equals DC_WDATA).
- MM_ACK  in  1  beat complete; MM_RDATA valid in the same cycle.
- MM_RDATA  in  32  read data.
- ERR  out  1  sticky timeout flag. Present only with the optional feature.

Behaviour:
- Reset (RST_N=0 at a rising edge) takes effect on that edge:
  - state=IDLE, all GNT/VALID/DONE/WREADY/MM_REQ/MM_WE/ERR = 0;
  - BEAT_IDX = 0, MM_ADDR = 0, last_owner = DC, so the I-cache wins the first tie.
- Reset mid-burst aborts the burst immediately. No DONE pulse is issued; requesters must re-request.
- States are IDLE, BURST and DONE.
- IDLE:
  - Samples IC_REQ/DC_REQ at the edge.
  - One request pending: grant it.
  - Both pending: grant the requester that is not last_owner.
  - On grant: latch owner, line base address and DC_WE (0 for the I-cache); set BEAT_IDX=0; go to BURST.
  - GNT and MM_REQ rise in the first BURST cycle, one cycle after REQ is sampled.
- BURST:
  - MM_REQ=1.
  - MM_ADDR = {latched line base, BEAT_IDX, 2'b00}.
  - MM_WE = latched WE.
  - The owner's GNT is held at 1.
- A beat completes in any BURST cycle with MM_ACK=1:
  - Read burst: the owner's RVALID = MM_ACK and RDATA = MM_RDATA, combinational, in the same cycle.
  - Write burst: DC_WREADY = MM_ACK in the same cycle, and DC_WDATA must be valid for BEAT_IDX.
  - BEAT_IDX increments at the edge.
  - Beat WORDS_PER_LINE-1 acked: BEAT_IDX wraps to 0 and the FSM goes to DONE.
- MM_ACK outside BURST is ignored.
- Requester REQ/ADDR/WE changes after grant are ignored; the latched values are used.
- DONE:
  - For one cycle: GNT=0, MM_REQ=0, the owner's DONE=1; last_owner <= owner; go to IDLE.
  - Minimum spacing between bursts is therefore 2 idle-side cycles.
- A requester keeps REQ high until its DONE. REQ still high in IDLE after DONE is treated as a new request.
- IC_GNT and DC_GNT are never high together. The RVALID/WREADY outputs of the non-owner are always 0.

Optional Feature:
- Macro: LINE_FILL_ARBITER_TIMEOUT_EN.
- Defined:
  - A per-beat counter clears on each ack and on entry to BURST.
  - If it reaches TIMEOUT_CYCLES without MM_ACK: ERR is set (sticky until reset), the burst aborts and the FSM goes to DONE.
  - The owner still gets its DONE pulse; data delivered for that line is undefined.
- Undefined: no counter and no ERR port; the arbiter waits indefinitely for MM_ACK.

Test Plan:
- I-cache read: IC_REQ at 0x0040, memory acks every 4 cycles.
  - Expect IC_GNT one cycle later.
  - 8 IC_RVALID pulses at MM_ADDR 0x40..0x5C with RDATA matching memory.
  - IC_DONE one cycle after the last ack.
- D-cache writeback: DC_WE=1 to 0x6020, DC_WDATA=beat+1.
  - Memory holds 1..8 at 0x6020..0x603C.
  - 8 DC_WREADY pulses, then DC_DONE.
- Simultaneous requests from reset: IC wins first, then DC is granted.
  - Both held high continuously: grants alternate IC, DC, IC.
  - GNTs never overlap.
- Mid-burst change: DC_ADDR changed and DC_REQ dropped during beat 3.
  - The burst still completes all 8 beats at the originally latched line.
- Reset mid-burst: RST_N=0 during beat 5.
  - Next cycle: all outputs 0, no DONE pulse.
  - A fresh IC request is granted normally.
- Timeout (TIMEOUT_EN defined, TIMEOUT_CYCLES=64): MM_ACK withheld.
  - ERR=1 after 64 cycles, owner DONE pulses, FSM returns to IDLE.
  - ERR stays 1 until reset.
